// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I control definitions.
// Holds the opcode constants, the ALUOp encodings, the controller state and
// instruction-class enums, the strobe bundle and a helper that decodes the
// Moore strobes for a given state/class pair.
package riscv_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned ALUOP_W  = 2;

    localparam logic [OPCODE_W-1:0] OP_R     = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I     = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LUI   = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OP_LOAD  = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE = 7'b0100011;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WRITEBACK,
        TRAP
    } state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LUI,
        CLS_LOAD,
        CLS_STORE
    } instrClass_t;

    // Datapath strobes that depend only on state and latched class.
    typedef struct packed {
        logic               instrRead;
        logic               regWrite;
        logic               aluSrc;
        logic [ALUOP_W-1:0] aluOp;
        logic               memRead;
        logic               memWrite;
        logic               memToReg;
        logic               illegal;
    } ctrl_t;

    // Moore strobe decode for one state/class pair.
    function automatic ctrl_t stateCtrl(input state_t st, input instrClass_t cls);
        ctrl_t c;
        c = '0;
        if (st == EXECUTE || st == MEM || st == WRITEBACK) begin
            c.aluSrc = (cls != CLS_R);
            c.aluOp  = (cls == CLS_R || cls == CLS_I) ? ALUOP_FUNCT : ALUOP_ADD;
        end
        case (st)
            FETCH:     c.instrRead = 1'b1;
            MEM: begin
                c.memRead  = (cls == CLS_LOAD);
                c.memWrite = (cls == CLS_STORE);
            end
            WRITEBACK: begin
                c.regWrite = 1'b1;
                c.memToReg = (cls == CLS_LOAD);
            end
            TRAP:      c.illegal = 1'b1;
            default:   ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/op_decode.sv
// op_decode: combinational opcode classifier.
// Ports:
//   opcode        in   instruction[6:0]
//   instrClass_c  out  instruction class (CLS_R when not legal)
//   legal_c       out  1 when opcode is one of the supported classes
module op_decode
    import riscv_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output instrClass_t         instrClass_c,
    output logic                legal_c
);

    // Map supported opcodes to their class; everything else is illegal.
    always_comb begin
        instrClass_c = CLS_R;
        legal_c      = 1'b1;
        case (opcode)
            OP_R:     instrClass_c = CLS_R;
            OP_I:     instrClass_c = CLS_I;
            OP_LUI:   instrClass_c = CLS_LUI;
            OP_LOAD:  instrClass_c = CLS_LOAD;
            OP_STORE: instrClass_c = CLS_STORE;
            default:  legal_c      = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: sequencing FSM for the multi-cycle RV32I datapath.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK, waits
// on instr_ready and mem_ready, counts retired instructions and traps on
// unsupported opcodes.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   opcode                      IR[6:0], sampled in DECODE only
//   instr_ready, mem_ready      memory handshakes
//   InstrRead                   fetch request
//   IRWrite, PCWrite            IR load / PC+4, gated by instr_ready in FETCH
//   RegWrite, ALUSrc, ALUOp     register-file write, ALU operand select/class
//   MemRead, MemWrite, MemToReg data memory strobes and write-back select
//   illegal                     sticky trap flag
//   instret                     retired-instruction count
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                instr_ready,
    input  logic                mem_ready,
    output logic                InstrRead,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                RegWrite,
    output logic                ALUSrc,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemToReg,
    output logic                illegal,
    output logic [CNT_W-1:0]    instret
);

    state_t      state;
    state_t      nextState;
    instrClass_t instrClass;
    instrClass_t nextClass;
    instrClass_t decClass;
    logic        decLegal;
    logic        retire;
    ctrl_t       ctrlQ;

    op_decode uOpDecode (
        .opcode       (opcode),
        .instrClass_c (decClass),
        .legal_c      (decLegal)
    );

    // Next-state, class latch and retirement decode.
    always_comb begin
        nextState = state;
        nextClass = instrClass;
        retire    = 1'b0;
        case (state)
            IDLE:  nextState = FETCH;
            FETCH: begin
                if (instr_ready) nextState = DECODE;
            end
            DECODE: begin
                if (decLegal) begin
                    nextState = EXECUTE;
                    nextClass = decClass;
                end else begin
                    nextState = TRAP;
                end
            end
            EXECUTE: begin
                if (instrClass == CLS_LOAD || instrClass == CLS_STORE) nextState = MEM;
                else                                                  nextState = WRITEBACK;
            end
            MEM: begin
                if (mem_ready) begin
                    if (instrClass == CLS_STORE) begin
                        nextState = FETCH;
                        retire    = 1'b1;
                    end else begin
                        nextState = WRITEBACK;
                    end
                end
            end
            WRITEBACK: begin
                nextState = FETCH;
                retire    = 1'b1;
            end
            TRAP:    nextState = TRAP;
            default: nextState = IDLE;
        endcase
    end

    // State, class, counter and strobes; strobes are registered from the
    // next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            instrClass <= CLS_R;
            ctrlQ      <= '0;
            instret    <= '0;
        end else begin
            state      <= nextState;
            instrClass <= nextClass;
            ctrlQ      <= stateCtrl(nextState, nextClass);
            if (retire) instret <= instret + CNT_W'(1);
        end
    end

    // IR/PC load is the only strobe that follows instr_ready in the same cycle.
    assign IRWrite   = (state == FETCH) && instr_ready;
    assign PCWrite   = (state == FETCH) && instr_ready;

    assign InstrRead = ctrlQ.instrRead;
    assign RegWrite  = ctrlQ.regWrite;
    assign ALUSrc    = ctrlQ.aluSrc;
    assign ALUOp     = ctrlQ.aluOp;
    assign MemRead   = ctrlQ.memRead;
    assign MemWrite  = ctrlQ.memWrite;
    assign MemToReg  = ctrlQ.memToReg;
    assign illegal   = ctrlQ.illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed self-checking bench with a scoreboard
// of per-cycle expected strobes and retired-instruction counts.
module tb_multicycle_controller;

    localparam logic [6:0] T_R      = 7'b0110011;
    localparam logic [6:0] T_I      = 7'b0010011;
    localparam logic [6:0] T_LUI    = 7'b0110111;
    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        instr_ready;
    logic        mem_ready;
    logic        InstrRead, IRWrite, PCWrite, RegWrite, ALUSrc;
    logic [1:0]  ALUOp;
    logic        MemRead, MemWrite, MemToReg, illegal;
    logic [31:0] instret;

    always #5 clk = ~clk;

    multicycle_controller #(.CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .instr_ready (instr_ready),
        .mem_ready   (mem_ready),
        .InstrRead   (InstrRead),
        .IRWrite     (IRWrite),
        .PCWrite     (PCWrite),
        .RegWrite    (RegWrite),
        .ALUSrc      (ALUSrc),
        .ALUOp       (ALUOp),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemToReg    (MemToReg),
        .illegal     (illegal),
        .instret     (instret)
    );

    // [10]InstrRead [9]IRWrite [8]PCWrite [7]RegWrite [6]ALUSrc [5:4]ALUOp
    // [3]MemRead [2]MemWrite [1]MemToReg [0]illegal
    logic [10:0] dutVec;
    assign dutVec = {InstrRead, IRWrite, PCWrite, RegWrite, ALUSrc, ALUOp,
                     MemRead, MemWrite, MemToReg, illegal};

    typedef struct {
        string       tag;
        logic [10:0] strobes;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          nCmp = 0;
    int          nFail = 0;
    logic [31:0] expCnt;

    // {ALUSrc, ALUOp} expected in EXECUTE/MEM/WRITEBACK.
    function automatic logic [2:0] aluBits(input logic [6:0] op);
        if (op == T_R) return 3'b010;
        if (op == T_I) return 3'b110;
        return 3'b100;
    endfunction

    function automatic logic [10:0] vFetch(input logic ir);
        return {1'b1, ir, ir, 8'b0};
    endfunction

    function automatic logic [10:0] vExec(input logic [6:0] op);
        return {4'b0, aluBits(op), 4'b0};
    endfunction

    function automatic logic [10:0] vMem(input logic [6:0] op);
        return {4'b0, aluBits(op), op == T_LOAD, op == T_STORE, 2'b0};
    endfunction

    function automatic logic [10:0] vWb(input logic [6:0] op);
        return {3'b0, 1'b1, aluBits(op), 2'b0, op == T_LOAD, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [10:0] v, input logic [31:0] cnt);
        exp_t e;
        e.tag     = tag;
        e.strobes = v;
        e.cnt     = cnt;
        sb.push_back(e);
    endtask

    task automatic popCompare();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({e.tag, "/strobes"}, 32'(dutVec), 32'(e.strobes));
            check({e.tag, "/instret"}, instret, e.cnt);
        end
    endtask

    // Called at posedge+1 with inputs already driven; checks at negedge.
    task automatic cycle(input string tag, input logic [10:0] v);
        push(tag, v, expCnt);
        @(negedge clk);
        popCompare();
        @(posedge clk);
        #1;
    endtask

    // One instruction with no wait states, starting from FETCH.
    task automatic runSimple(input logic [6:0] op, input string tag);
        opcode      = op;
        instr_ready = 1'b1;
        mem_ready   = 1'b1;
        cycle({tag, "_fetch"}, vFetch(1'b1));
        cycle({tag, "_decode"}, 11'b0);
        cycle({tag, "_exec"}, vExec(op));
        if (op == T_LOAD || op == T_STORE) cycle({tag, "_mem"}, vMem(op));
        if (op == T_STORE) begin
            expCnt = expCnt + 32'd1;
        end else begin
            cycle({tag, "_wb"}, vWb(op));
            expCnt = expCnt + 32'd1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        opcode      = T_R;
        instr_ready = 1'b0;
        mem_ready   = 1'b0;
        expCnt      = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        cycle("in_reset", 11'b0);

        // Release: one IDLE cycle, then FETCH.
        rst_n       = 1'b1;
        instr_ready = 1'b1;
        cycle("idle", 11'b0);

        // Back-to-back ADD.
        runSimple(T_R, "add0");
        runSimple(T_R, "add1");
        runSimple(T_R, "add2");
        check("instret_after_3_add", instret, 32'd3);

        // LOAD with three MEM wait cycles; opcode changes after DECODE.
        opcode    = T_LOAD;
        mem_ready = 1'b0;
        cycle("ld_fetch", vFetch(1'b1));
        cycle("ld_decode", 11'b0);
        opcode = T_BRANCH;
        cycle("ld_exec", vExec(T_LOAD));
        for (int i = 0; i < 3; i++) cycle("ld_mem_wait", vMem(T_LOAD));
        mem_ready = 1'b1;
        cycle("ld_mem_done", vMem(T_LOAD));
        mem_ready = 1'b0;
        cycle("ld_wb", vWb(T_LOAD));
        expCnt = expCnt + 32'd1;

        // STORE, then I-type and LUI.
        runSimple(T_STORE, "st");
        runSimple(T_I, "addi");
        runSimple(T_LUI, "lui");
        check("instret_after_mix", instret, 32'd7);

        // FETCH with two instr_ready wait cycles.
        opcode      = T_I;
        instr_ready = 1'b0;
        cycle("fw_wait0", vFetch(1'b0));
        cycle("fw_wait1", vFetch(1'b0));
        instr_ready = 1'b1;
        cycle("fw_ready", vFetch(1'b1));
        cycle("fw_decode", 11'b0);
        cycle("fw_exec", vExec(T_I));
        cycle("fw_wb", vWb(T_I));
        expCnt = expCnt + 32'd1;

        // Reset asserted during a LOAD MEM wait.
        opcode    = T_LOAD;
        mem_ready = 1'b0;
        cycle("rl_fetch", vFetch(1'b1));
        cycle("rl_decode", 11'b0);
        cycle("rl_exec", vExec(T_LOAD));
        cycle("rl_mem_wait", vMem(T_LOAD));
        rst_n  = 1'b0;
        expCnt = 32'd0;
        #1;
        push("rst_async", 11'b0, expCnt);
        popCompare();
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        instr_ready = 1'b1;
        opcode      = T_BRANCH;
        cycle("rst_idle", 11'b0);
        cycle("rst_fetch", vFetch(1'b1));

        // Unsupported opcode traps; handshakes ignored while trapped.
        cycle("trap_decode", 11'b0);
        for (int i = 0; i < 100; i++) begin
            instr_ready = 1'($urandom_range(0, 1));
            mem_ready   = 1'($urandom_range(0, 1));
            opcode      = T_R;
            cycle("trap_hold", 11'b1);
        end

        // Reset clears the trap.
        rst_n  = 1'b0;
        #1;
        push("trap_reset", 11'b0, expCnt);
        popCompare();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing controller for the multi-cycle RV32I datapath. Steps each instruction through fetch, decode, execute, memory and write-back states. Handles wait-state handshakes with instruction and data memory. Drives the datapath strobes: register-file write, ALU operand select and ALU op class, memory read/write, write-back mux, PC and IR enables. Counts retired instructions, and traps on unsupported opcodes.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- opcode  input  7  instruction[6:0] from IR; sampled only in DECODE
- instr_ready  input  1  instruction memory has valid data this cycle
- mem_ready  input  1  data memory completes the current read/write this cycle
- InstrRead  output  1  instruction fetch request
- IRWrite  output  1  load IR from instruction memory
- PCWrite  output  1  PC <= PC + 4
- RegWrite  output  1  register-file write enable
- ALUSrc  output  1  0 = rs2, 1 = immediate
- ALUOp  output  2  00 = add (address/LUI), 10 = funct-decoded
- MemRead  output  1  data memory read request
- MemWrite  output  1  data memory write request
- MemToReg  output  1  0 = ALU result, 1 = memory data to write-back
- illegal  output  1  sticky trap flag
- instret  output  CNT_W  retired-instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP. Reset state is IDLE.
- IDLE: all strobes 0. Unconditionally goes to FETCH next cycle.
- FETCH: InstrRead=1 while in state.
  - On the cycle instr_ready=1, also assert IRWrite=1 and PCWrite=1 (a one-cycle pulse), then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: classify opcode and latch the class into an internal register.
  - Classes: R 0110011, I 0010011, LUI 0110111, LOAD 0000011, STORE 0100011. Any other opcode → TRAP.
  - Later states use only the latched class, so opcode may change after DECODE.
- EXECUTE, MEM, WRITEBACK: drive ALUSrc/ALUOp from the latched class.
  - R: ALUSrc=0, ALUOp=10.
  - I: ALUSrc=1, ALUOp=10.
  - LUI, LOAD, STORE: ALUSrc=1, ALUOp=00.
  - In all other states ALUSrc=0, ALUOp=00.
- EXECUTE: one cycle. R/I/LUI → WRITEBACK; LOAD/STORE → MEM.
- MEM: LOAD holds MemRead=1 and STORE holds MemWrite=1 until mem_ready=1 (that cycle included).
  - On mem_ready: LOAD → WRITEBACK, STORE → FETCH.
- WRITEBACK: RegWrite=1 for exactly one cycle. MemToReg=1 for LOAD, else 0. Then → FETCH.
- Retirement happens on the WRITEBACK cycle, or the STORE MEM cycle with mem_ready=1.
  - instret increments by 1 on retirement and wraps modulo 2^CNT_W.
- TRAP: illegal=1, all other strobes 0, PC/IR frozen. Absorbing state, left only by reset. instret is not incremented for the trapping instruction.
- MemRead and MemWrite are never both 1. RegWrite is never 1 outside WRITEBACK.

## Timing
- All outputs are Moore-decoded from state and latched class, except IRWrite/PCWrite, which are gated by instr_ready in FETCH.
- While rst_n=0: state=IDLE, class=R, illegal=0, instret=0, all strobes 0.
- Reset mid-instruction aborts immediately, so no partial RegWrite or MemWrite is issued after rst_n falls.
- Latency with zero wait states (FETCH entry to next FETCH entry):
  - R/I/LUI: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
- Each instr_ready/mem_ready wait cycle adds 1 cycle.
- instr_ready outside FETCH and mem_ready outside MEM are ignored.
- After reset release, the first InstrRead is asserted the cycle after IDLE.

## Structure
- Shared package riscv_pkg holds:
  - opcode constants (OP_R, OP_I, OP_LUI, OP_LOAD, OP_STORE);
  - ALUOp encodings (ALUOP_ADD=00, ALUOP_FUNCT=10);
  - state enum and instruction-class enum.
- One combinational sub-module, op_decode: opcode → {class, legal}. Reusable by the single-cycle path.
- The FSM, class register and instret counter live in multicycle_controller.

## Test plan
- Back-to-back ADD (0110011), instr_ready tied 1 → RegWrite pulses every 4 cycles, ALUSrc=0/ALUOp=10 in EXECUTE; instret=3 after 3 instructions.
- LOAD (0000011) with mem_ready low for 3 MEM cycles → MemRead high for 4 cycles, then WRITEBACK with RegWrite=1 and MemToReg=1; total 8 cycles.
- STORE (0100011) with mem_ready=1 → MemWrite=1 one cycle, RegWrite never 1, FETCH follows directly; instret +1.
- FETCH with instr_ready low 2 cycles → InstrRead=1 for 3 cycles, IRWrite/PCWrite exactly one pulse, on the 3rd.
- Opcode 1100011 in DECODE → TRAP; illegal=1 held for 100 cycles, all strobes 0, instret unchanged.
- rst_n low during LOAD MEM wait → all outputs 0 and instret=0 asynchronously. After release: IDLE then FETCH, with InstrRead=1 on the 2nd cycle.
